// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the program-memory loader.
// Optional feature macro: PROG_MEM_CHECKSUM_EN (adds the ld_sum output).
package prog_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Wide enough for any DATA_W; narrowed at the point of use.
  localparam logic [63:0] NOP = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Load-stream and fetch bus between the host/CPU side and the loader.
// ld_sum exists only when PROG_MEM_CHECKSUM_EN is defined.
interface prog_mem_loader_if
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              cpu_run;
  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic [DATA_W-1:0] op_code;
  logic              op_valid;
  logic [ADDR_W:0]   prog_len;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] ld_sum;
`endif

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, pc, fetch_req,
    input  ld_ready, ld_done, cpu_run, op_code, op_valid, prog_len
`ifdef PROG_MEM_CHECKSUM_EN
    , input ld_sum
`endif
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, pc, fetch_req,
    output ld_ready, ld_done, cpu_run, op_code, op_valid, prog_len
`ifdef PROG_MEM_CHECKSUM_EN
    , output ld_sum
`endif
  );

endinterface

// File: rtl/prog_ram.sv
// Simple dual-port program RAM: synchronous write, registered read.
module prog_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Loads a program word stream into RAM, then releases the CPU and serves fetches.
// Define PROG_MEM_CHECKSUM_EN to add the running ld_sum checksum output.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst,
  prog_mem_loader_if.slave bus
);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              cpu_run_q;
  logic              op_valid_q;
  logic              nop_q;
  logic [DATA_W-1:0] rd_data;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] ld_sum_q;
`endif

  logic accept;
  logic wr_en;
  logic fetch_ok;
  logic mem_full;

  assign accept   = ld_ready_q & bus.ld_valid;
  // A restart in the same cycle wins over the word on the bus.
  assign wr_en    = accept & ~bus.ld_start;
  assign fetch_ok = cpu_run_q & bus.fetch_req;
  assign mem_full = (wr_ptr_q == {ADDR_W{1'b1}});

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.ld_data),
    .re_i    (fetch_ok),
    .raddr_i (bus.pc),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      cpu_run_q  <= 1'b0;
      op_valid_q <= 1'b0;
      nop_q      <= 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
      ld_sum_q   <= '0;
`endif
    end else begin
      // Fetch path runs independently so a fetch issued alongside ld_start completes.
      op_valid_q <= fetch_ok;
      if (fetch_ok) nop_q <= ({1'b0, bus.pc} >= prog_len_q);
      ld_done_q <= 1'b0;

      if (bus.ld_start) begin
        state_q    <= ST_LOAD;
        ld_ready_q <= 1'b1;
        cpu_run_q  <= 1'b0;
        wr_ptr_q   <= '0;
        prog_len_q <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
        ld_sum_q   <= '0;
`endif
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (accept) begin
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              prog_len_q <= prog_len_q + 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
              ld_sum_q   <= ld_sum_q + bus.ld_data;
`endif
              if (bus.ld_last || mem_full) begin
                state_q    <= ST_DONE;
                ld_ready_q <= 1'b0;
                ld_done_q  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state_q   <= ST_RUN;
            cpu_run_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.cpu_run  = cpu_run_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_code  = (op_valid_q && !nop_q) ? rd_data : DATA_W'(NOP);
  assign bus.prog_len = prog_len_q;
`ifdef PROG_MEM_CHECKSUM_EN
  assign bus.ld_sum   = ld_sum_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a word-level reference model.
module tb_prog_mem_loader;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prog_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: loading / done-pulse / running flags plus a word array.
  logic [DW-1:0] mem_m [DEPTH];
  bit  m_loading, m_done, m_running;
  bit  was_run;
  int  wp, e_len;
  bit  e_opv;
  logic [DW-1:0] e_op;
  logic [DW-1:0] e_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 0; m_done = 0; m_running = 0;
      e_opv = 0; e_op = '0; e_len = 0; wp = 0; e_sum = '0;
    end else begin
      was_run = m_running;
      e_opv   = was_run && bus.fetch_req;
      if (e_opv) e_op = (int'(bus.pc) < e_len) ? mem_m[bus.pc] : '0;
      if (bus.ld_start) begin
        m_loading = 1; m_running = 0; m_done = 0;
        wp = 0; e_len = 0; e_sum = '0;
      end else if (m_loading) begin
        m_done = 0;
        if (bus.ld_valid) begin
          mem_m[wp] = bus.ld_data;
          wp++; e_len++;
          e_sum = e_sum + bus.ld_data;
          if (bus.ld_last || e_len == DEPTH) begin
            m_loading = 0; m_done = 1;
          end
        end
      end else if (m_done) begin
        m_done = 0; m_running = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("ld_ready", 32'(bus.ld_ready), 32'(m_loading));
      chk("ld_done",  32'(bus.ld_done),  32'(m_done));
      chk("cpu_run",  32'(bus.cpu_run),  32'(m_running));
      chk("op_valid", 32'(bus.op_valid), 32'(e_opv));
      chk("prog_len", 32'(bus.prog_len), 32'(e_len));
      if (e_opv) chk("op_code", 32'(bus.op_code), 32'(e_op));
`ifdef PROG_MEM_CHECKSUM_EN
      chk("ld_sum", 32'(bus.ld_sum), 32'(e_sum));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0;
    bus.ld_data = '0; bus.fetch_req = 0; bus.pc = '0;
  endtask

  logic [DW-1:0] big [DEPTH];
  int r;

  initial begin
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);
    chk("rst_cpu_run",  32'(bus.cpu_run),  0);
    chk("rst_op_valid", 32'(bus.op_valid), 0);
    chk("rst_op_code",  32'(bus.op_code),  0);
    chk("rst_prog_len", 32'(bus.prog_len), 0);
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Three-word program, then sequential fetch including one past the end.
    bus.ld_start = 1; tick();
    bus.ld_start = 0;
    chk("load_ready", 32'(bus.ld_ready), 1);
    bus.ld_valid = 1; bus.ld_data = 8'h1A; tick();
    bus.ld_data = 8'h2B; tick();
    bus.ld_data = 8'h3C; bus.ld_last = 1; tick();
    chk("done_pulse", 32'(bus.ld_done), 1);
    chk("done_ready", 32'(bus.ld_ready), 0);
    chk("done_len",   32'(bus.prog_len), 3);
    chk("done_run",   32'(bus.cpu_run), 0);
    bus.ld_valid = 0; bus.ld_last = 0; tick();
    chk("run_on",     32'(bus.cpu_run), 1);
    chk("done_clear", 32'(bus.ld_done), 0);
    bus.fetch_req = 1;
    bus.pc = 0; tick(); chk("fetch0", 32'(bus.op_code), 32'h1A);
    bus.pc = 1; tick(); chk("fetch1", 32'(bus.op_code), 32'h2B);
    bus.pc = 2; tick(); chk("fetch2", 32'(bus.op_code), 32'h3C);
    bus.pc = 3; tick(); chk("fetch3_nop", 32'(bus.op_code), 32'h00);
    chk("fetch3_vld", 32'(bus.op_valid), 1);

    // Restart from RUN with a fetch in flight.
    bus.pc = 1; bus.ld_start = 1; tick();
    chk("restart_opv",   32'(bus.op_valid), 1);
    chk("restart_op",    32'(bus.op_code), 32'h2B);
    chk("restart_run",   32'(bus.cpu_run), 0);
    chk("restart_ready", 32'(bus.ld_ready), 1);
    bus.ld_start = 0; bus.fetch_req = 0; tick();
    chk("fetch_ignored", 32'(bus.op_valid), 0);

    // Fill the whole memory without ld_last.
    for (int i = 0; i < DEPTH; i++) begin
      big[i] = DW'($urandom);
      bus.ld_valid = 1; bus.ld_data = big[i]; tick();
    end
    chk("full_len",   32'(bus.prog_len), DEPTH);
    chk("full_done",  32'(bus.ld_done), 1);
    chk("full_ready", 32'(bus.ld_ready), 0);
    bus.ld_data = 8'hEE; tick();
    bus.ld_valid = 0;
    chk("full_ready2", 32'(bus.ld_ready), 0);
    chk("full_run",    32'(bus.cpu_run), 1);
    bus.fetch_req = 1; bus.pc = 8'hFF; tick();
    chk("full_last_word", 32'(bus.op_code), 32'(big[DEPTH-1]));
    bus.pc = 0; tick();
    chk("full_first_word", 32'(bus.op_code), 32'(big[0]));
    bus.fetch_req = 0;

    // Reset in the middle of a load.
    bus.ld_start = 1; tick();
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 8'h11; tick();
    bus.ld_data = 8'h22; tick();
    bus.ld_valid = 0;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ld_ready), 0);
    chk("mid_rst_len",   32'(bus.prog_len), 0);
    chk("mid_rst_done",  32'(bus.ld_done), 0);
    chk("mid_rst_run",   32'(bus.cpu_run), 0);
    tick();
    rst = 1'b0;
    bus.ld_start = 1; tick();
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 8'h55; tick();
    bus.ld_data = 8'h66; bus.ld_last = 1; tick();
    bus.ld_valid = 0; bus.ld_last = 0; tick();
    bus.fetch_req = 1; bus.pc = 0; tick();
    chk("reload_w0", 32'(bus.op_code), 32'h55);
    bus.pc = 2; tick();
    chk("reload_past_end", 32'(bus.op_code), 32'h00);
    bus.fetch_req = 0;

`ifdef PROG_MEM_CHECKSUM_EN
    bus.ld_start = 1; tick();
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 8'hFF; tick();
    bus.ld_data = 8'h02; bus.ld_last = 1; tick();
    chk("checksum", 32'(bus.ld_sum), 32'h01);
    bus.ld_valid = 0; bus.ld_last = 0; tick();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      bus.ld_start  = (r < 3);
      bus.ld_valid  = $urandom_range(0, 1) == 1;
      bus.ld_last   = $urandom_range(0, 7) == 0;
      bus.ld_data   = DW'($urandom);
      bus.fetch_req = $urandom_range(0, 1) == 1;
      bus.pc        = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the program-counter and memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, the instruction (opcode plus operand) width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port ld_start, input, 1, a request to begin or restart a program load.
REQ-006 SHALL have port ld_valid, input, 1, marking a load byte as present on ld_data.
REQ-007 SHALL have port ld_data, input, DATA_W, the instruction word being loaded.
REQ-008 SHALL have port ld_last, input, 1, marking the final word of the program, qualified by ld_valid.
REQ-009 SHALL have port ld_ready, output, 1, indicating the block accepts a load word this cycle.
REQ-010 SHALL have port ld_done, output, 1, a one-cycle pulse when a load completes.
REQ-011 SHALL have port cpu_run, output, 1, the processor run enable; low holds the CPU stalled.
REQ-012 SHALL have port pc, input, ADDR_W, the processor fetch address.
REQ-013 SHALL have port fetch_req, input, 1, the processor fetch strobe.
REQ-014 SHALL have port op_code, output, DATA_W, the fetched instruction.
REQ-015 SHALL have port op_valid, output, 1, qualifying op_code for one cycle.
REQ-016 SHALL have port prog_len, output, ADDR_W+1, the number of words loaded.

Function
REQ-017 SHALL implement the states IDLE, LOAD, DONE and RUN.
REQ-018 IDLE SHALL move to LOAD on ld_start, clearing the write pointer and prog_len.
REQ-019 In LOAD, ld_ready SHALL be 1 and each word accepted (ld_valid & ld_ready) SHALL be written to mem[wr_ptr], with wr_ptr and prog_len incremented.
REQ-020 LOAD SHALL move to DONE after accepting a word with ld_last=1, or after accepting word 2^ADDR_W-1 (memory full, implicit last).
REQ-021 DONE SHALL last exactly one cycle with ld_done=1 and ld_ready=0, then move to RUN.
REQ-022 RUN SHALL drive cpu_run=1; a fetch_req SHALL return op_code=mem[pc] with op_valid=1 on the next cycle (latency 1), and back-to-back fetches SHALL be supported every cycle.
REQ-023 A fetch at pc >= prog_len SHALL return NOP (all zeros) with op_valid=1.
REQ-024 A fetch_req outside RUN SHALL be ignored, with op_valid=0.
REQ-025 ld_start in RUN or DONE SHALL re-enter LOAD; cpu_run SHALL drop on the next cycle, and any fetch issued in that same cycle SHALL still complete.
REQ-026 ld_start during LOAD SHALL restart the load at address 0; a word accepted in that same cycle SHALL be discarded.
REQ-027 ld_valid outside LOAD SHALL be ignored and no memory write SHALL occur.

Reset
REQ-028 rst SHALL force state=IDLE, ld_ready=0, ld_done=0, cpu_run=0, op_valid=0, op_code=0 and prog_len=0 immediately and asynchronously.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 rst asserted mid-load SHALL abandon the load and leave prog_len=0.

Configuration
REQ-031 When PROG_MEM_CHECKSUM_EN is defined, an extra output ld_sum (DATA_W) SHALL hold the modulo-2^DATA_W sum of all accepted words; it SHALL be cleared on entry to LOAD and reset to 0.
REQ-032 When PROG_MEM_CHECKSUM_EN is undefined, the ld_sum port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Package prog_mem_pkg SHALL hold the state enum, the ADDR_W and DATA_W defaults, and the NOP constant.
REQ-034 Sub-module prog_ram SHALL be a simple dual-port RAM with synchronous write and registered read, instantiated once.

Verification
REQ-035 Reset, ld_start, then words 0x1A,0x2B,0x3C with ld_last on 0x3C -> ld_done one cycle later, prog_len=3, cpu_run=1 the cycle after that.
REQ-036 In RUN, fetch pc=0,1,2,3 on consecutive cycles -> op_code 0x1A,0x2B,0x3C,0x00 each one cycle later, op_valid continuous.
REQ-037 Load 256 words without ld_last -> DONE after word 255, prog_len=256, ld_ready=0 afterwards.
REQ-038 rst asserted after 2 of 3 words -> all outputs at reset values within the same cycle; a fetch after the next load completes sees the new data.
REQ-039 ld_start in RUN with a simultaneous fetch at pc=1 -> op_valid=1 with 0x2B, then cpu_run=0 and ld_ready=1.
REQ-040 With PROG_MEM_CHECKSUM_EN defined, load 0xFF,0x02 -> ld_sum=0x01.
